// File: rtl/fifo_drain_ctrl_if.sv
// Handshake bundle between the drain controller, the FIFO read port and the consumer.
// The master side is the controller; the slave side is the FIFO/consumer environment.
interface fifo_drain_ctrl_if #(
  parameter int DATA_BITS = 10
);
  logic                 fifo_empty_in;
  logic [DATA_BITS-1:0] fifo_data_in;
  logic                 fifo_read_out;
  logic [DATA_BITS-1:0] data_out;
  logic                 valid_out;
  logic                 ready_in;

  modport master (
    input  fifo_empty_in, fifo_data_in, ready_in,
    output fifo_read_out, data_out, valid_out
  );

  modport slave (
    output fifo_empty_in, fifo_data_in, ready_in,
    input  fifo_read_out, data_out, valid_out
  );
endinterface

// File: rtl/fifo_drain_ctrl.sv
// Read-side drain controller for xfifo: issues reads, absorbs the 1-cycle RAM latency
// in a 2-entry output buffer and delivers words on a valid/ready handshake.
//
// state | meaning
// IDLE  | not draining; no reads issued
// RUN   | draining; reads issued while the FIFO has data and the buffer has room
// FLUSH | no new reads; waits for buffered and in-flight words to leave
module fifo_drain_ctrl #(
  parameter int DATA_BITS  = 10,
  parameter int COUNT_BITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable_in,
  fifo_drain_ctrl_if.master     bus,
  output logic [COUNT_BITS-1:0] drained_cnt_out,
  output logic                  idle_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t               state;
  logic [1:0]           occ;
  logic                 inflight;
  logic [DATA_BITS-1:0] head;
  logic [DATA_BITS-1:0] tail;

  logic       valid;
  logic       pop;
  logic       rd;
  logic [1:0] load;

  // load counts buffered plus in-flight words; it never exceeds 2
  always_comb begin
    valid = (occ != 2'd0);
    pop   = valid && bus.ready_in;
    load  = occ + {1'b0, inflight};
    rd    = (state == RUN) && !bus.fifo_empty_in &&
            ((load <= 2'd1) || ((load == 2'd2) && pop));
  end

  assign bus.fifo_read_out = rd;
  assign bus.valid_out     = valid;
  assign bus.data_out      = head;
  assign idle_out          = (state == IDLE) && (occ == 2'd0) && !inflight;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      occ             <= 2'd0;
      inflight        <= 1'b0;
      head            <= '0;
      tail            <= '0;
      drained_cnt_out <= '0;
    end else begin
      inflight <= rd;
      if (pop) drained_cnt_out <= drained_cnt_out + 1'b1;

      case (state)
        IDLE:    if (enable_in) state <= RUN;
        RUN:     if (!enable_in) state <= FLUSH;
        FLUSH: begin
          if (enable_in) state <= RUN;
          else if ((occ == 2'd0) && !inflight) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // capture of the in-flight word always lands behind whatever is left after a pop
      if (inflight && pop) begin
        if (occ == 2'd1) begin
          head <= bus.fifo_data_in;
        end else begin
          head <= tail;
          tail <= bus.fifo_data_in;
        end
      end else if (inflight) begin
        if (occ == 2'd0) head <= bus.fifo_data_in;
        else             tail <= bus.fifo_data_in;
        occ <= occ + 2'd1;
      end else if (pop) begin
        head <= tail;
        occ  <= occ - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed bench for fifo_drain_ctrl: a queue-backed FIFO model with 1-cycle read data,
// a per-cycle vector table for the streaming case and short sequences for the corner cases.
module tb_fifo_drain_ctrl;
  localparam int DB = 10;
  localparam int CB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [CB-1:0] cnt;
  logic          idle;

  fifo_drain_ctrl_if #(.DATA_BITS(DB)) bus ();

  fifo_drain_ctrl #(.DATA_BITS(DB), .COUNT_BITS(CB)) dut (
    .clk             (clk),
    .reset           (reset),
    .enable_in       (enable),
    .bus             (bus),
    .drained_cnt_out (cnt),
    .idle_out        (idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          en;
    logic          rdy;
    logic          rd;
    logic          valid;
    logic [DB-1:0] data;
    int            cnt;
    logic          idle;
  } vec_t;

  vec_t          tbl[13];
  logic [DB-1:0] q[$];
  logic [DB-1:0] dq[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            rd_count = 0;
  int            empty_viol = 0;
  logic          s_rd, s_valid, s_idle;
  logic [DB-1:0] s_data;
  int            s_cnt;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // one clock: drive at negedge, sample just after, then advance the FIFO model past posedge
  task automatic cyc(input logic rst, input logic en, input logic rdy);
    @(negedge clk);
    reset = rst;
    enable = en;
    bus.ready_in = rdy;
    bus.fifo_empty_in = (q.size() == 0);
    #1;
    s_rd    = bus.fifo_read_out;
    s_valid = bus.valid_out;
    s_data  = bus.data_out;
    s_cnt   = int'(cnt);
    s_idle  = idle;
    if (s_rd && q.size() == 0) empty_viol++;
    @(posedge clk);
    #1;
    if (s_rd) begin
      if (q.size() > 0) bus.fifo_data_in = q.pop_front();
      rd_count++;
    end
    if (s_valid && rdy && !rst) dq.push_back(s_data);
    bus.fifo_empty_in = (q.size() == 0);
  endtask

  initial begin
    bus.ready_in = 1'b0;
    bus.fifo_data_in = '0;
    bus.fifo_empty_in = 1'b1;

    //        en    rdy   rd    valid data     cnt idle
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 0, 1'b1};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 10'h000, 0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 10'h000, 0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 10'h000, 0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 10'h001, 0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 10'h002, 1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 10'h003, 2, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 10'h004, 3, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 10'h005, 4, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 10'h000, 5, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 5, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 5, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 5, 1'b1};

    // T1: reset held with data available and enable high
    q = '{10'h0AA, 10'h0AB, 10'h0AC};
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b1, 1'b1);
      chk($sformatf("t1_rd[%0d]", i), s_rd, 0);
      chk($sformatf("t1_valid[%0d]", i), s_valid, 0);
      chk($sformatf("t1_data[%0d]", i), s_data, 0);
      chk($sformatf("t1_cnt[%0d]", i), s_cnt, 0);
      chk($sformatf("t1_idle[%0d]", i), s_idle, 1);
    end
    q.delete();
    rd_count = 0;

    // T2: streaming, table driven
    for (int i = 1; i <= 5; i++) q.push_back(DB'(i));
    for (int i = 0; i < 13; i++) begin
      cyc(1'b0, tbl[i].en, tbl[i].rdy);
      chk($sformatf("t2_rd[%0d]", i), s_rd, tbl[i].rd);
      chk($sformatf("t2_valid[%0d]", i), s_valid, tbl[i].valid);
      if (tbl[i].valid) chk($sformatf("t2_data[%0d]", i), s_data, tbl[i].data);
      chk($sformatf("t2_cnt[%0d]", i), s_cnt, tbl[i].cnt);
      chk($sformatf("t2_idle[%0d]", i), s_idle, tbl[i].idle);
    end
    chk("t2_reads", rd_count, 5);

    // T3: backpressure after the first accepted word
    rd_count = 0;
    dq.delete();
    for (int i = 1; i <= 5; i++) q.push_back(DB'(i));
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1);
    chk("t3_first_valid", s_valid, 1);
    chk("t3_first_data", s_data, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      chk($sformatf("t3_stall_rd[%0d]", i), s_rd, 0);
      chk($sformatf("t3_stall_valid[%0d]", i), s_valid, 1);
      chk($sformatf("t3_stall_data[%0d]", i), s_data, 2);
    end
    chk("t3_reads_stalled", rd_count, 3);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b1);
    chk("t3_reads", rd_count, 5);
    chk("t3_words", dq.size(), 5);
    for (int i = 0; i < dq.size(); i++) chk($sformatf("t3_word[%0d]", i), dq[i], i + 1);
    chk("t3_cnt", s_cnt, 10);

    // T4: enable drops in the same cycle as a read
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1);
    chk("t4_pre_idle", s_idle, 1);
    rd_count = 0;
    dq.delete();
    q = '{10'h010, 10'h011, 10'h012};
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("t4_rd_at_drop", s_rd, 1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1);
    chk("t4_reads", rd_count, 1);
    chk("t4_words", dq.size(), 1);
    if (dq.size() > 0) chk("t4_word", dq[0], 'h010);
    chk("t4_idle", s_idle, 1);
    chk("t4_cnt", s_cnt, 11);
    q.delete();

    // T5: a single word arriving while running
    rd_count = 0;
    dq.delete();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1);
    chk("t5_no_read_empty", rd_count, 0);
    q.push_back(10'h3FF);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b1);
    chk("t5_reads", rd_count, 1);
    chk("t5_words", dq.size(), 1);
    if (dq.size() > 0) chk("t5_word", dq[0], 'h3FF);
    chk("t5_cnt", s_cnt, 12);

    // T7: reset while the buffer is full
    q = '{10'h021, 10'h022, 10'h023, 10'h024};
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0);
    chk("t7_full_valid", s_valid, 1);
    chk("t7_full_data", s_data, 'h021);
    cyc(1'b1, 1'b1, 1'b0);
    q.delete();
    cyc(1'b0, 1'b0, 1'b0);
    chk("t7_valid", s_valid, 0);
    chk("t7_idle", s_idle, 1);
    chk("t7_cnt", s_cnt, 0);
    chk("t7_rd", s_rd, 0);

    // T6: 17 deliveries wrap the 4-bit counter to 1
    rd_count = 0;
    dq.delete();
    for (int i = 0; i < 17; i++) q.push_back(DB'(32'h100 + i));
    for (int i = 0; i < 24; i++) cyc(1'b0, 1'b1, 1'b1);
    chk("t6_words", dq.size(), 17);
    for (int i = 0; i < dq.size(); i++) chk($sformatf("t6_word[%0d]", i), dq[i], 'h100 + i);
    chk("t6_reads", rd_count, 17);
    chk("t6_cnt", s_cnt, 1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1);
    chk("t6_idle", s_idle, 1);

    chk("read_while_empty", empty_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
